m68k_dtack_gen: RTL

M68K_DTACK_GEN -- requirements
Module: m68k_dtack_gen

---
 rtl/prehistoric_pkg.sv | 21 ++
 rtl/m68k_dtack_gen_if.sv | 28 ++
 rtl/m68k_bus_timer.sv | 29 ++
 rtl/m68k_dtack_gen.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/prehistoric_pkg.sv
// Shared types and default bus-timing constants for the 68k glue logic.
// Pure declarations, no latency; no flow control involved.
// Counts are in clk_en ticks; the timer is 8 bits wide.
package prehistoric_pkg;

    localparam int TIMER_W      = 8;
    localparam int DEF_RAM_WAIT = 1;
    localparam int DEF_IO_WAIT  = 2;
    localparam int DEF_TIMEOUT  = 255;

    typedef logic [TIMER_W-1:0] tick_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_WAIT,
        ST_CNT_WAIT,
        ST_ACK,
        ST_BERR
    } bus_state_t;

endpackage

// File: rtl/m68k_dtack_gen_if.sv
// 68k bus-cycle handshake bundle between the CPU/decoder side and the DTACK generator.
// Wires only, no latency.
// The strobe and acknowledge lines themselves form the handshake; no extra backpressure.
interface m68k_dtack_gen_if;

    logic m68k_as_n;
    logic m68k_rw;
    logic m68k_rom_cs;
    logic m68k_ram_cs;
    logic m68k_io_cs;
    logic rom_ack;
    logic rom_req;
    logic m68k_dtack_n;
    logic m68k_berr_n;
    logic busy;
    logic cycle_rw;

    modport slave (
        input  m68k_as_n, m68k_rw, m68k_rom_cs, m68k_ram_cs, m68k_io_cs, rom_ack,
        output rom_req, m68k_dtack_n, m68k_berr_n, busy, cycle_rw
    );

    modport master (
        output m68k_as_n, m68k_rw, m68k_rom_cs, m68k_ram_cs, m68k_io_cs, rom_ack,
        input  rom_req, m68k_dtack_n, m68k_berr_n, busy, cycle_rw
    );

endinterface

// File: rtl/m68k_bus_timer.sv
// Wait-state down-counter: load has priority, decrements on clk_en, stops at zero.
// Load takes effect the next clk; zero flag is combinational from the count.
// No backpressure; the count is simply held once it reaches zero.
module m68k_bus_timer
    import prehistoric_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      clk_en,
    input  logic      load,
    input  tick_cnt_t load_val,
    output logic      zero
);

    tick_cnt_t count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clk_en && (count != '0)) begin
            count <= count - tick_cnt_t'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/m68k_dtack_gen.sv
// 68k DTACK/BERR generator; M68K_BERR_TIMEOUT_EN turns unmapped/ROM timeouts into bus errors.
// Latency: RAM/IO waits +1 clk_en tick after start; ROM acks the clk after rom_ack.
// Strobes are held until a clk_en samples AS high; an early AS release aborts silently.
module m68k_dtack_gen
    import prehistoric_pkg::*;
#(
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    m68k_dtack_gen_if.slave bus
);

    bus_state_t state;
    logic       as_prev;
    logic       dtack_q;
    logic       rom_req_q;
    logic       busy_q;
    logic       rw_q;
    logic       start;
    logic       strobe_up;
    logic       tmr_load;
    logic       tmr_zero;
    tick_cnt_t  tmr_val;
`ifdef M68K_BERR_TIMEOUT_EN
    logic       berr_q;
    logic       unmapped;
`endif

    assign start     = clk_en && !bus.m68k_as_n && as_prev;
    assign strobe_up = clk_en && bus.m68k_as_n;
    assign tmr_load  = start && (state == ST_IDLE);

    // ROM loads TIMEOUT so the same counter can bound the SDRAM wait.
    always_comb begin
        tmr_val = tick_cnt_t'(IO_WAIT);
        if (bus.m68k_rom_cs)      tmr_val = tick_cnt_t'(TIMEOUT);
        else if (bus.m68k_ram_cs) tmr_val = tick_cnt_t'(RAM_WAIT);
        else if (bus.m68k_io_cs)  tmr_val = tick_cnt_t'(IO_WAIT);
`ifdef M68K_BERR_TIMEOUT_EN
        else                      tmr_val = tick_cnt_t'(TIMEOUT);
`endif
    end

    m68k_bus_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            dtack_q   <= 1'b1;
            rom_req_q <= 1'b0;
            busy_q    <= 1'b0;
            as_prev   <= 1'b1;
            rw_q      <= 1'b0;
`ifdef M68K_BERR_TIMEOUT_EN
            berr_q    <= 1'b1;
            unmapped  <= 1'b0;
`endif
        end else begin
            rom_req_q <= 1'b0;
            if (clk_en) as_prev <= bus.m68k_as_n;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        rw_q   <= bus.m68k_rw;
`ifdef M68K_BERR_TIMEOUT_EN
                        unmapped <= !(bus.m68k_rom_cs || bus.m68k_ram_cs || bus.m68k_io_cs);
`endif
                        if (bus.m68k_rom_cs) begin
                            state     <= ST_ROM_WAIT;
                            rom_req_q <= 1'b1;
                        end else begin
                            state <= ST_CNT_WAIT;
                        end
                    end
                end
                ST_ROM_WAIT: begin
                    if (strobe_up) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.rom_ack) begin
                        state   <= ST_ACK;
                        dtack_q <= 1'b0;
                    end
`ifdef M68K_BERR_TIMEOUT_EN
                    else if (clk_en && tmr_zero) begin
                        state  <= ST_BERR;
                        berr_q <= 1'b0;
                    end
`endif
                end
                ST_CNT_WAIT: begin
                    if (strobe_up) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (clk_en && tmr_zero) begin
`ifdef M68K_BERR_TIMEOUT_EN
                        if (unmapped) begin
                            state  <= ST_BERR;
                            berr_q <= 1'b0;
                        end else begin
                            state   <= ST_ACK;
                            dtack_q <= 1'b0;
                        end
`else
                        state   <= ST_ACK;
                        dtack_q <= 1'b0;
`endif
                    end
                end
                ST_ACK, ST_BERR: begin
                    if (strobe_up) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        dtack_q <= 1'b1;
`ifdef M68K_BERR_TIMEOUT_EN
                        berr_q  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_req      = rom_req_q;
    assign bus.m68k_dtack_n = dtack_q;
    assign bus.busy         = busy_q;
    assign bus.cycle_rw     = rw_q;
`ifdef M68K_BERR_TIMEOUT_EN
    assign bus.m68k_berr_n  = berr_q;
`else
    assign bus.m68k_berr_n  = 1'b1;
`endif

endmodule
